// File: rtl/input_deserializer_if.sv
//==============================================================================
// Module      : input_deserializer_if
// Description : Bus bundle between a serial bit source/word consumer and the
//               input_deserializer. The slave modport is the deserializer
//               side; the master modport drives the serial bits and ready.
//               Signals:
//                 en_i           - dataBit_i is a valid payload bit
//                 dataBit_i      - received, unstuffed serial bit
//                 flush_i        - end of packet / abort, drops partial word
//                 ready_i        - consumer accepts data_o this cycle
//                 data_o         - completed word in holding register
//                 dataValid_o    - holding register occupied
//                 bitCount_o     - bits collected in the current partial word
//                 overflow_o     - sticky: a completed word was dropped
//                 partialFlush_o - pulse: flush arrived with a partial word
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface input_deserializer_if #(
    parameter int LENGTH = 8
);
    localparam int CW = $clog2(LENGTH + 1);

    logic              en_i;
    logic              dataBit_i;
    logic              flush_i;
    logic              ready_i;
    logic [LENGTH-1:0] data_o;
    logic              dataValid_o;
    logic [CW-1:0]     bitCount_o;
    logic              overflow_o;
    logic              partialFlush_o;

    modport slave (
        input  en_i,
        input  dataBit_i,
        input  flush_i,
        input  ready_i,
        output data_o,
        output dataValid_o,
        output bitCount_o,
        output overflow_o,
        output partialFlush_o
    );

    modport master (
        output en_i,
        output dataBit_i,
        output flush_i,
        output ready_i,
        input  data_o,
        input  dataValid_o,
        input  bitCount_o,
        input  overflow_o,
        input  partialFlush_o
    );
endinterface

`default_nettype wire

// File: rtl/input_deserializer.sv
//==============================================================================
// Module      : input_deserializer
// Description : Receive-side serial-to-parallel converter for the USB SIE.
//               Collects NRZI-decoded, bit-unstuffed bits into LENGTH-bit
//               words and presents each word through a single-entry holding
//               register with a valid/ready handshake. Flags dropped words
//               (sticky overflow) and partial words discarded by a flush.
//               Ports:
//                 clk12_i - 12 MHz bit clock
//                 rst_i   - asynchronous active-high reset
//                 bus     - input_deserializer_if.slave (bits in, words out)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module input_deserializer #(
    parameter int LENGTH    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  wire logic               clk12_i,
    input  wire logic               rst_i,
    input_deserializer_if.slave     bus
);

    localparam int            CW          = $clog2(LENGTH + 1);
    localparam logic [CW-1:0] c_LAST_BIT  = CW'(LENGTH - 1);
    localparam logic [CW-1:0] c_COUNT_ONE = CW'(1);

    logic [LENGTH-1:0] r_buf;
    logic [CW-1:0]     r_count;
    logic [LENGTH-1:0] r_data;
    logic              r_valid;
    logic              r_overflow;
    logic              r_partial_flush;

    logic [LENGTH-1:0] w_shifted;
    logic              w_shift;
    logic              w_complete;
    logic              w_accept;

    // Shift direction decides where the first received bit ends up.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shifted = {bus.dataBit_i, r_buf[LENGTH-1:1]};
        end else begin : g_msb_first
            assign w_shifted = {r_buf[LENGTH-2:0], bus.dataBit_i};
        end
    endgenerate

    // Flush takes priority over a payload bit presented in the same cycle.
    assign w_shift    = bus.en_i && !bus.flush_i;
    assign w_complete = w_shift && (r_count == c_LAST_BIT);
    assign w_accept   = r_valid && bus.ready_i;

    // Shift buffer, bit counter and status flags.
    always_ff @(posedge clk12_i or posedge rst_i) begin
        if (rst_i) begin
            r_buf           <= '0;
            r_count         <= '0;
            r_overflow      <= 1'b0;
            r_partial_flush <= 1'b0;
        end else begin
            r_partial_flush <= 1'b0;
            if (bus.flush_i) begin
                r_buf           <= '0;
                r_count         <= '0;
                r_overflow      <= 1'b0;
                r_partial_flush <= (r_count != '0);
            end else if (w_shift) begin
                if (w_complete) begin
                    r_buf   <= '0;
                    r_count <= '0;
                    // Word completes while the holding register is still
                    // occupied and not being drained: the new word is lost.
                    if (r_valid && !bus.ready_i) begin
                        r_overflow <= 1'b1;
                    end
                end else begin
                    r_buf   <= w_shifted;
                    r_count <= r_count + c_COUNT_ONE;
                end
            end
        end
    end

    // Single-entry holding register. A completion on the same edge as an
    // accept replaces the word without a bubble; flush never touches it.
    always_ff @(posedge clk12_i or posedge rst_i) begin
        if (rst_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_complete && (!r_valid || bus.ready_i)) begin
                r_data  <= w_shifted;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.data_o         = r_data;
    assign bus.dataValid_o    = r_valid;
    assign bus.bitCount_o     = r_count;
    assign bus.overflow_o     = r_overflow;
    assign bus.partialFlush_o = r_partial_flush;

endmodule

`default_nettype wire

// File: tb/tb_input_deserializer.sv
//==============================================================================
// Module      : tb_input_deserializer
// Description : Directed self-checking bench for input_deserializer. Two
//               instances (LSB-first and MSB-first, LENGTH = 8) receive the
//               same serial stimulus; each scenario task checks the instance
//               it targets.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_input_deserializer;

    localparam int LENGTH = 8;

    logic clk;
    logic rst;
    logic r_en;
    logic r_bit;
    logic r_flush;
    logic r_ready;

    int checks;
    int failures;

    input_deserializer_if #(.LENGTH(LENGTH)) bus_lsb ();
    input_deserializer_if #(.LENGTH(LENGTH)) bus_msb ();

    assign bus_lsb.en_i      = r_en;
    assign bus_lsb.dataBit_i = r_bit;
    assign bus_lsb.flush_i   = r_flush;
    assign bus_lsb.ready_i   = r_ready;
    assign bus_msb.en_i      = r_en;
    assign bus_msb.dataBit_i = r_bit;
    assign bus_msb.flush_i   = r_flush;
    assign bus_msb.ready_i   = r_ready;

    input_deserializer #(.LENGTH(LENGTH), .LSB_FIRST(1'b1)) u_lsb (
        .clk12_i (clk),
        .rst_i   (rst),
        .bus     (bus_lsb.slave)
    );

    input_deserializer #(.LENGTH(LENGTH), .LSB_FIRST(1'b0)) u_msb (
        .clk12_i (clk),
        .rst_i   (rst),
        .bus     (bus_msb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are observed 1 ns after
    // the rising edge that sampled them.
    task automatic drive(input logic en, input logic b, input logic fl, input logic rdy);
        @(negedge clk);
        r_en    = en;
        r_bit   = b;
        r_flush = fl;
        r_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic rdy);
        for (int i = 0; i < 8; i++) drive(1'b1, v[i], 1'b0, rdy);
    endtask

    task automatic test_reset();
        checks++;
        if ({bus_lsb.data_o, bus_lsb.dataValid_o, bus_lsb.bitCount_o,
             bus_lsb.overflow_o, bus_lsb.partialFlush_o} !== 15'd0) begin
            failures++;
            $display("FAIL reset_lsb got data=%h v=%b cnt=%0d ov=%b pf=%b required all 0",
                     bus_lsb.data_o, bus_lsb.dataValid_o, bus_lsb.bitCount_o,
                     bus_lsb.overflow_o, bus_lsb.partialFlush_o);
        end
        checks++;
        if ({bus_msb.data_o, bus_msb.dataValid_o, bus_msb.bitCount_o,
             bus_msb.overflow_o, bus_msb.partialFlush_o} !== 15'd0) begin
            failures++;
            $display("FAIL reset_msb got data=%h v=%b cnt=%0d ov=%b pf=%b required all 0",
                     bus_msb.data_o, bus_msb.dataValid_o, bus_msb.bitCount_o,
                     bus_msb.overflow_o, bus_msb.partialFlush_o);
        end
    endtask

    // Bits 1,0,1,0,0,1,0,1 -> 0xA5 in both bit orders.
    task automatic test_lsb_byte();
        logic [7:0] bits;
        bits = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, bits[7-i], 1'b0, 1'b1);
            if (i == 2) begin
                checks++;
                if (bus_lsb.bitCount_o !== 4'd3) begin
                    failures++;
                    $display("FAIL lsb_count_mid got=%0d required=3", bus_lsb.bitCount_o);
                end
                checks++;
                if (bus_lsb.dataValid_o !== 1'b0) begin
                    failures++;
                    $display("FAIL lsb_valid_early got=%b required=0", bus_lsb.dataValid_o);
                end
            end
        end
        checks++;
        if (bus_lsb.data_o !== 8'hA5 || bus_lsb.dataValid_o !== 1'b1 || bus_lsb.bitCount_o !== 4'd0) begin
            failures++;
            $display("FAIL lsb_word got data=%h v=%b cnt=%0d required data=a5 v=1 cnt=0",
                     bus_lsb.data_o, bus_lsb.dataValid_o, bus_lsb.bitCount_o);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus_lsb.dataValid_o !== 1'b0) begin
            failures++;
            $display("FAIL lsb_accept got v=%b required=0", bus_lsb.dataValid_o);
        end
    endtask

    task automatic test_msb_gaps();
        logic [7:0] bits;
        bits = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, bits[7-i], 1'b0, 1'b1);
            if (i < 7) begin
                checks++;
                if (bus_msb.bitCount_o !== 4'(i + 1)) begin
                    failures++;
                    $display("FAIL msb_count_bit%0d got=%0d required=%0d", i, bus_msb.bitCount_o, i + 1);
                end
                drive(1'b0, ~bits[7-i], 1'b0, 1'b1);
                checks++;
                if (bus_msb.bitCount_o !== 4'(i + 1)) begin
                    failures++;
                    $display("FAIL msb_count_gap%0d got=%0d required=%0d", i, bus_msb.bitCount_o, i + 1);
                end
            end
        end
        checks++;
        if (bus_msb.data_o !== 8'hA5 || bus_msb.dataValid_o !== 1'b1 || bus_msb.bitCount_o !== 4'd0) begin
            failures++;
            $display("FAIL msb_word got data=%h v=%b cnt=%0d required data=a5 v=1 cnt=0",
                     bus_msb.data_o, bus_msb.dataValid_o, bus_msb.bitCount_o);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_overflow();
        send_byte(8'h11, 1'b0);
        checks++;
        if (bus_lsb.data_o !== 8'h11 || bus_lsb.dataValid_o !== 1'b1 || bus_lsb.overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_first got data=%h v=%b ov=%b required data=11 v=1 ov=0",
                     bus_lsb.data_o, bus_lsb.dataValid_o, bus_lsb.overflow_o);
        end
        // Same bits seen MSB-first: 1000_1000.
        checks++;
        if (bus_msb.data_o !== 8'h88) begin
            failures++;
            $display("FAIL ovf_first_msb got data=%h required=88", bus_msb.data_o);
        end
        send_byte(8'h22, 1'b0);
        checks++;
        if (bus_lsb.data_o !== 8'h11 || bus_lsb.dataValid_o !== 1'b1 || bus_lsb.overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drop got data=%h v=%b ov=%b required data=11 v=1 ov=1",
                     bus_lsb.data_o, bus_lsb.dataValid_o, bus_lsb.overflow_o);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus_lsb.dataValid_o !== 1'b0 || bus_lsb.overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky got v=%b ov=%b required v=0 ov=1",
                     bus_lsb.dataValid_o, bus_lsb.overflow_o);
        end
        send_byte(8'h66, 1'b0);
        checks++;
        if (bus_lsb.data_o !== 8'h66 || bus_lsb.overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_after_word got data=%h ov=%b required data=66 ov=1",
                     bus_lsb.data_o, bus_lsb.overflow_o);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus_lsb.overflow_o !== 1'b0 || bus_lsb.partialFlush_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_flush got ov=%b pf=%b required ov=0 pf=0",
                     bus_lsb.overflow_o, bus_lsb.partialFlush_o);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        send_byte(8'h33, 1'b0);
        v = 8'h44;
        for (int i = 0; i < 8; i++) drive(1'b1, v[i], 1'b0, (i == 7));
        checks++;
        if (bus_lsb.data_o !== 8'h44 || bus_lsb.dataValid_o !== 1'b1 || bus_lsb.overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b got data=%h v=%b ov=%b required data=44 v=1 ov=0",
                     bus_lsb.data_o, bus_lsb.dataValid_o, bus_lsb.overflow_o);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus_lsb.dataValid_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain got v=%b required=0", bus_lsb.dataValid_o);
        end
    endtask

    task automatic test_flush();
        send_byte(8'h5A, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus_lsb.bitCount_o !== 4'd3) begin
            failures++;
            $display("FAIL flush_pre_count got=%0d required=3", bus_lsb.bitCount_o);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus_lsb.bitCount_o !== 4'd0 || bus_lsb.partialFlush_o !== 1'b1 ||
            bus_lsb.data_o !== 8'h5A || bus_lsb.dataValid_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_partial got cnt=%0d pf=%b data=%h v=%b required cnt=0 pf=1 data=5a v=1",
                     bus_lsb.bitCount_o, bus_lsb.partialFlush_o, bus_lsb.data_o, bus_lsb.dataValid_o);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus_lsb.partialFlush_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_pulse_len got pf=%b required=0", bus_lsb.partialFlush_o);
        end
        // Empty flush: no pulse, and the pending word is still accepted.
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus_lsb.partialFlush_o !== 1'b0 || bus_lsb.dataValid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_empty got pf=%b v=%b required pf=0 v=0",
                     bus_lsb.partialFlush_o, bus_lsb.dataValid_o);
        end
        // Next word after a flush must not carry stale bits.
        send_byte(8'h81, 1'b0);
        checks++;
        if (bus_lsb.data_o !== 8'h81) begin
            failures++;
            $display("FAIL flush_clean_word got data=%h required=81", bus_lsb.data_o);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        logic [7:0] v;
        send_byte(8'h55, 1'b0);
        v = 8'hFF;
        for (int i = 0; i < 5; i++) drive(1'b1, v[i], 1'b0, 1'b0);
        @(negedge clk);
        r_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus_lsb.data_o, bus_lsb.dataValid_o, bus_lsb.bitCount_o,
             bus_lsb.overflow_o, bus_lsb.partialFlush_o} !== 15'd0) begin
            failures++;
            $display("FAIL async_reset got data=%h v=%b cnt=%0d ov=%b pf=%b required all 0",
                     bus_lsb.data_o, bus_lsb.dataValid_o, bus_lsb.bitCount_o,
                     bus_lsb.overflow_o, bus_lsb.partialFlush_o);
        end
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'hC3, 1'b1);
        checks++;
        if (bus_lsb.data_o !== 8'hC3 || bus_lsb.dataValid_o !== 1'b1 || bus_lsb.overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_word got data=%h v=%b ov=%b required data=c3 v=1 ov=0",
                     bus_lsb.data_o, bus_lsb.dataValid_o, bus_lsb.overflow_o);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        r_en     = 1'b0;
        r_bit    = 1'b0;
        r_flush  = 1'b0;
        r_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_lsb_byte();
        test_msb_gaps();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
